obi_sbr_reg_bridge: RTL

OBI subordinate that terminates one crossbar output port (subordinate-side OBI types: 32-bit address/data, widened ID) and converts every granted OBI transaction into one register-interface (regbus) access. It sits between the main crossbar (or peripheral demux) and a regbus device such as SoC control, UART, GPIO or timer, and returns the regbus result as an OBI response. One transaction is in flight at a time, with a registered request stage and a single-cycle response.

---
 rtl/obi_sbr_reg_bridge_pkg.sv | 50 +++++
 rtl/obi_sbr_reg_bridge.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/obi_sbr_reg_bridge_pkg.sv
// Bus types shared by obi_sbr_reg_bridge and its users: subordinate-side OBI
// (32-bit address/data, widened ID) and the register-interface channel.
package obi_sbr_reg_bridge_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned IdW   = 4;

    typedef struct packed {
        logic [AddrW-1:0]   addr;
        logic               we;
        logic [DataW/8-1:0] be;
        logic [DataW-1:0]   wdata;
        logic [IdW-1:0]     aid;
        logic               a_optional;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        sbr_obi_a_chan_t a;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [DataW-1:0] rdata;
        logic [IdW-1:0]   rid;
        logic             err;
        logic             r_optional;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

    typedef struct packed {
        logic [AddrW-1:0]   addr;
        logic               write;
        logic [DataW-1:0]   wdata;
        logic [DataW/8-1:0] wstrb;
        logic               valid;
    } reg_req_t;

    typedef struct packed {
        logic [DataW-1:0] rdata;
        logic             error;
        logic             ready;
    } reg_rsp_t;

endpackage

// File: rtl/obi_sbr_reg_bridge.sv
// OBI subordinate to regbus bridge: one transaction in flight, registered request, single-cycle response.
// Optional access timeout enabled by defining OBI_REG_BRIDGE_TIMEOUT_EN.
module obi_sbr_reg_bridge
    import obi_sbr_reg_bridge_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  sbr_obi_req_t obi_req_i,
    output sbr_obi_rsp_t obi_rsp_o,
    output reg_req_t     reg_req_o,
    input  reg_rsp_t     reg_rsp_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic               we_q, we_d;
    logic [DataW/8-1:0] be_q, be_d;
    logic [DataW-1:0]   wdata_q, wdata_d;
    logic [IdW-1:0]     aid_q, aid_d;
    logic [DataW-1:0]   rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               gnt;
    logic               accept;
    logic               timeout;
    logic               unused_a_optional;

    assign unused_a_optional = obi_req_i.a.a_optional;

    // Grant depends on state alone so the manager never sees a req->gnt loop.
    assign gnt    = !rst_i && (state_q == IDLE || state_q == RESP);
    assign accept = obi_req_i.req && gnt;

`ifdef OBI_REG_BRIDGE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == ACCESS) && !reg_rsp_i.ready && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == ACCESS && !reg_rsp_i.ready && cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    localparam int unsigned UnusedTimeoutCycles = TimeoutCycles;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        aid_d   = aid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) state_d = ACCESS;
            ACCESS: begin
                // A late ready still beats the timeout in the same cycle.
                if (reg_rsp_i.ready) begin
                    state_d = RESP;
                    rdata_d = reg_rsp_i.rdata;
                    err_d   = reg_rsp_i.error;
                end else if (timeout) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            RESP:    state_d = accept ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            addr_d  = obi_req_i.a.addr;
            we_d    = obi_req_i.a.we;
            be_d    = obi_req_i.a.be;
            wdata_d = obi_req_i.a.wdata;
            aid_d   = obi_req_i.a.aid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            aid_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            aid_q   <= aid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Both bus outputs come only from state and holding registers.
    always_comb begin
        obi_rsp_o     = '0;
        obi_rsp_o.gnt = gnt;
        if (state_q == RESP) begin
            obi_rsp_o.rvalid  = 1'b1;
            obi_rsp_o.r.rid   = aid_q;
            obi_rsp_o.r.err   = err_q;
            obi_rsp_o.r.rdata = we_q ? '0 : rdata_q;
        end
    end

    always_comb begin
        reg_req_o = '0;
        if (state_q == ACCESS) begin
            reg_req_o.valid = 1'b1;
            reg_req_o.addr  = addr_q;
            reg_req_o.write = we_q;
            reg_req_o.wdata = wdata_q;
            reg_req_o.wstrb = be_q;
        end
    end

endmodule
